// File: rtl/board_score_keeper_pkg.sv
// Shared board and score definitions used by the score keeper and the game controller.
package board_score_keeper_pkg;

    localparam int BOARD_CELLS = 9;
    localparam int BCD_W       = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Cell index, row-major from the top-left corner; cell i maps to bit i of a board vector.
    typedef enum logic [3:0] {
        CELL_TL = 4'd0, CELL_TC = 4'd1, CELL_TR = 4'd2,
        CELL_ML = 4'd3, CELL_MC = 4'd4, CELL_MR = 4'd5,
        CELL_BL = 4'd6, CELL_BC = 4'd7, CELL_BR = 4'd8
    } cell_idx_t;

    // One-hot board mask for a single cell.
    function automatic logic [BOARD_CELLS-1:0] cell_mask(input cell_idx_t idx);
        logic [BOARD_CELLS-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // Number of set bits in a board vector (0..9).
    function automatic logic [3:0] cell_count(input logic [BOARD_CELLS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < BOARD_CELLS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/board_score_keeper_bcd_score_counter.sv
// Two-digit BCD win counter that counts rising edges of a held win level.
module bcd_score_counter
    import board_score_keeper_pkg::*;
(
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc_level,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    logic inc_prev;

    // Edge register always tracks the input (even in reset/clear) so a held level counts once.
    always_ff @(posedge clk_100MHz) begin
        inc_prev <= inc_level;
        if (reset || clear) begin
            tens  <= '0;
            units <= '0;
        end else if (inc_level && !inc_prev) begin
            if (units == BCD_MAX) begin
                units <= '0;
                tens  <= (tens == BCD_MAX) ? '0 : tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/board_score_keeper.sv
// Tic-tac-toe board occupancy, move counter and per-player BCD score keeper.
module board_score_keeper
    import board_score_keeper_pkg::*;
(
    input  logic                   clk_100MHz,
    input  logic                   reset,
    input  logic [BOARD_CELLS-1:0] almacenar_x,
    input  logic [BOARD_CELLS-1:0] almacenar_o,
    input  logic                   resetPosiciones,
    input  logic                   resetScore,
    input  logic                   inc_x_score,
    input  logic                   inc_o_score,
    output logic [BOARD_CELLS-1:0] x,
    output logic [BOARD_CELLS-1:0] o,
    output logic [BCD_W-1:0]       score_x_tens,
    output logic [BCD_W-1:0]       score_x_units,
    output logic [BCD_W-1:0]       score_o_tens,
    output logic [BCD_W-1:0]       score_o_units,
    output logic [3:0]             move_count,
    output logic                   board_full,
    output logic                   write_reject
);

    logic [BOARD_CELLS-1:0] free_cells;
    logic [BOARD_CELLS-1:0] acc_x;
    logic [BOARD_CELLS-1:0] acc_o;
    logic                   dropped;

    // A cell is writable only if empty and not contested by the other player in the same cycle.
    always_comb begin
        free_cells = ~(x | o);
        acc_x      = almacenar_x & free_cells & ~almacenar_o;
        acc_o      = almacenar_o & free_cells & ~almacenar_x;
        dropped    = |((almacenar_x | almacenar_o) & ~(acc_x | acc_o));
    end

    assign board_full = &(x | o);

    // Board state and move count; only free cells are ever accepted so the count stays within 0..9.
    always_ff @(posedge clk_100MHz) begin
        if (reset || resetPosiciones) begin
            x            <= '0;
            o            <= '0;
            move_count   <= 4'd0;
            write_reject <= 1'b0;
        end else begin
            x            <= x | acc_x;
            o            <= o | acc_o;
            move_count   <= move_count + cell_count(acc_x | acc_o);
            write_reject <= dropped;
        end
    end

    bcd_score_counter u_score_x (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (resetScore),
        .inc_level  (inc_x_score),
        .tens       (score_x_tens),
        .units      (score_x_units)
    );

    bcd_score_counter u_score_o (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (resetScore),
        .inc_level  (inc_o_score),
        .tens       (score_o_tens),
        .units      (score_o_units)
    );

endmodule

// File: tb/tb_board_score_keeper.sv
// Directed self-checking bench for board_score_keeper.
module tb_board_score_keeper;

    logic       clk_100MHz;
    logic       reset;
    logic [8:0] almacenar_x;
    logic [8:0] almacenar_o;
    logic       resetPosiciones;
    logic       resetScore;
    logic       inc_x_score;
    logic       inc_o_score;
    logic [8:0] x;
    logic [8:0] o;
    logic [3:0] score_x_tens;
    logic [3:0] score_x_units;
    logic [3:0] score_o_tens;
    logic [3:0] score_o_units;
    logic [3:0] move_count;
    logic       board_full;
    logic       write_reject;

    int checks = 0;
    int errors = 0;

    board_score_keeper dut (
        .clk_100MHz      (clk_100MHz),
        .reset           (reset),
        .almacenar_x     (almacenar_x),
        .almacenar_o     (almacenar_o),
        .resetPosiciones (resetPosiciones),
        .resetScore      (resetScore),
        .inc_x_score     (inc_x_score),
        .inc_o_score     (inc_o_score),
        .x               (x),
        .o               (o),
        .score_x_tens    (score_x_tens),
        .score_x_units   (score_x_units),
        .score_o_tens    (score_o_tens),
        .score_o_units   (score_o_units),
        .move_count      (move_count),
        .board_full      (board_full),
        .write_reject    (write_reject)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic idle();
        almacenar_x = '0; almacenar_o = '0;
        resetPosiciones = 1'b0; resetScore = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); inc_x_score = 1'b0; inc_o_score = 1'b0;
        tick(); tick();
        checks++; if ({x, o} !== 18'h0) begin errors++; $display("FAIL reset_board got x=%h o=%h want 0", x, o); end
        checks++; if (move_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", move_count); end
        checks++; if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin errors++; $display("FAIL reset_scores got %h want 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units}); end
        checks++; if ({write_reject, board_full} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {write_reject, board_full}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_legal_moves();
        almacenar_x = 9'h010; tick(); idle();
        checks++; if (x !== 9'h010 || write_reject !== 1'b0) begin errors++; $display("FAIL legal_x got x=%h wr=%b want 010/0", x, write_reject); end
        almacenar_o = 9'h001; tick(); idle();
        checks++; if (o !== 9'h001 || x !== 9'h010) begin errors++; $display("FAIL legal_o got x=%h o=%h want 010/001", x, o); end
        checks++; if (move_count !== 4'd2 || write_reject !== 1'b0) begin errors++; $display("FAIL legal_count got mc=%0d wr=%b want 2/0", move_count, write_reject); end
    endtask

    task automatic test_conflicts();
        almacenar_o = 9'h010; tick(); idle();
        checks++; if (o !== 9'h001 || write_reject !== 1'b1) begin errors++; $display("FAIL occupied got o=%h wr=%b want 001/1", o, write_reject); end
        tick();
        checks++; if (write_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse got %b want 0", write_reject); end
        almacenar_x = 9'h100; almacenar_o = 9'h100; tick(); idle();
        checks++; if (x !== 9'h010 || o !== 9'h001 || write_reject !== 1'b1 || move_count !== 4'd2) begin errors++; $display("FAIL same_cell got x=%h o=%h wr=%b mc=%0d want 010/001/1/2", x, o, write_reject, move_count); end
    endtask

    task automatic test_multi_hot();
        almacenar_x = 9'h016; tick(); idle();
        checks++; if (x !== 9'h016 || write_reject !== 1'b1 || move_count !== 4'd4) begin errors++; $display("FAIL multi_partial got x=%h wr=%b mc=%0d want 016/1/4", x, write_reject, move_count); end
        almacenar_o = 9'h0C0; tick(); idle();
        checks++; if (o !== 9'h0C1 || write_reject !== 1'b0 || move_count !== 4'd6) begin errors++; $display("FAIL multi_free got o=%h wr=%b mc=%0d want 0C1/0/6", o, write_reject, move_count); end
    endtask

    task automatic test_held_win();
        inc_x_score = 1'b1;
        repeat (50) tick();
        checks++; if ({score_x_tens, score_x_units} !== 8'h01) begin errors++; $display("FAIL held_win got %h want 01", {score_x_tens, score_x_units}); end
        inc_x_score = 1'b0; tick();
        inc_x_score = 1'b1; tick();
        checks++; if ({score_x_tens, score_x_units} !== 8'h02) begin errors++; $display("FAIL rearm_win got %h want 02", {score_x_tens, score_x_units}); end
        inc_x_score = 1'b0; tick();
    endtask

    task automatic test_bcd_wrap();
        repeat (9) begin inc_o_score = 1'b1; tick(); inc_o_score = 1'b0; tick(); end
        checks++; if ({score_o_tens, score_o_units} !== 8'h09) begin errors++; $display("FAIL bcd_nine got %h want 09", {score_o_tens, score_o_units}); end
        inc_o_score = 1'b1; tick(); inc_o_score = 1'b0; tick();
        checks++; if ({score_o_tens, score_o_units} !== 8'h10) begin errors++; $display("FAIL bcd_carry got %h want 10", {score_o_tens, score_o_units}); end
        repeat (90) begin inc_o_score = 1'b1; tick(); inc_o_score = 1'b0; tick(); end
        checks++; if ({score_o_tens, score_o_units} !== 8'h00) begin errors++; $display("FAIL bcd_wrap got %h want 00", {score_o_tens, score_o_units}); end
        checks++; if ({score_x_tens, score_x_units} !== 8'h02) begin errors++; $display("FAIL score_indep got %h want 02", {score_x_tens, score_x_units}); end
    endtask

    task automatic test_simultaneous();
        inc_x_score = 1'b1; inc_o_score = 1'b1; tick();
        inc_x_score = 1'b0; inc_o_score = 1'b0; tick();
        checks++; if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0301) begin errors++; $display("FAIL simultaneous got %h want 0301", {score_x_tens, score_x_units, score_o_tens, score_o_units}); end
    endtask

    task automatic test_board_priority();
        resetPosiciones = 1'b1; almacenar_x = 9'h001; tick(); idle();
        checks++; if ({x, o} !== 18'h0 || move_count !== 4'd0 || write_reject !== 1'b0) begin errors++; $display("FAIL clear_board got x=%h o=%h mc=%0d wr=%b want 0/0/0/0", x, o, move_count, write_reject); end
        checks++; if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0301) begin errors++; $display("FAIL board_clear_scores got %h want 0301", {score_x_tens, score_x_units, score_o_tens, score_o_units}); end
    endtask

    task automatic test_score_priority();
        almacenar_x = 9'h100; tick(); idle();
        resetScore = 1'b1; inc_o_score = 1'b1; tick(); idle();
        checks++; if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin errors++; $display("FAIL score_clear got %h want 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units}); end
        repeat (5) tick();
        checks++; if ({score_o_tens, score_o_units} !== 8'h00) begin errors++; $display("FAIL score_held got %h want 00", {score_o_tens, score_o_units}); end
        checks++; if (x !== 9'h100 || move_count !== 4'd1) begin errors++; $display("FAIL score_clear_board got x=%h mc=%0d want 100/1", x, move_count); end
        inc_o_score = 1'b0; tick();
    endtask

    task automatic test_full_board_and_reset();
        resetPosiciones = 1'b1; tick(); idle();
        checks++; if (board_full !== 1'b0) begin errors++; $display("FAIL empty_full got %b want 0", board_full); end
        almacenar_x = 9'h155; almacenar_o = 9'h0AA; tick(); idle();
        checks++; if (board_full !== 1'b1 || move_count !== 4'd9 || write_reject !== 1'b0) begin errors++; $display("FAIL full got bf=%b mc=%0d wr=%b want 1/9/0", board_full, move_count, write_reject); end
        inc_x_score = 1'b1; tick(); inc_x_score = 1'b0; tick();
        checks++; if ({score_x_tens, score_x_units} !== 8'h01) begin errors++; $display("FAIL pre_reset_score got %h want 01", {score_x_tens, score_x_units}); end
        almacenar_x = 9'h001; tick(); idle();
        checks++; if (write_reject !== 1'b1 || move_count !== 4'd9) begin errors++; $display("FAIL full_reject got wr=%b mc=%0d want 1/9", write_reject, move_count); end
        reset = 1'b1; inc_x_score = 1'b1; almacenar_o = 9'h100; tick(); idle();
        checks++; if ({x, o} !== 18'h0 || move_count !== 4'd0 || write_reject !== 1'b0 || board_full !== 1'b0) begin errors++; $display("FAIL mid_reset got x=%h o=%h mc=%0d wr=%b bf=%b want all 0", x, o, move_count, write_reject, board_full); end
        checks++; if ({score_x_tens, score_x_units, score_o_tens, score_o_units} !== 16'h0000) begin errors++; $display("FAIL mid_reset_scores got %h want 0000", {score_x_tens, score_x_units, score_o_tens, score_o_units}); end
        reset = 1'b0;
        repeat (3) tick();
        checks++; if ({score_x_tens, score_x_units} !== 8'h00) begin errors++; $display("FAIL held_across_reset got %h want 00", {score_x_tens, score_x_units}); end
        inc_x_score = 1'b0; tick();
        inc_x_score = 1'b1; tick();
        checks++; if ({score_x_tens, score_x_units} !== 8'h01) begin errors++; $display("FAIL post_reset_win got %h want 01", {score_x_tens, score_x_units}); end
        inc_x_score = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_legal_moves();
        test_conflicts();
        test_multi_hot();
        test_held_win();
        test_bcd_wrap();
        test_simultaneous();
        test_board_priority();
        test_score_priority();
        test_full_board_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
